// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap controller: state encodings, cause codes,
// exception_i bit positions and the exception priority selector.
package trap_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_RESET       = 5'b00001,
    ST_OPERATING   = 5'b00010,
    ST_DRAIN       = 5'b00100,
    ST_TRAP_TAKEN  = 5'b01000,
    ST_TRAP_RETURN = 5'b10000
  } state_e;

  localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

  // Synchronous exception cause codes
  localparam logic [4:0] CAUSE_MISALIGNED_INST  = 5'd0;
  localparam logic [4:0] CAUSE_ILLEGAL_INST     = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT       = 5'd3;
  localparam logic [4:0] CAUSE_MISALIGNED_LOAD  = 5'd4;
  localparam logic [4:0] CAUSE_MISALIGNED_STORE = 5'd6;
  localparam logic [4:0] CAUSE_ECALL_M          = 5'd11;

  // Interrupt cause codes, which double as mie/mip bit positions
  localparam logic [4:0] CAUSE_MSI        = 5'd3;
  localparam logic [4:0] CAUSE_MTI        = 5'd7;
  localparam logic [4:0] CAUSE_MEI        = 5'd11;
  localparam int         CAUSE_LOCAL_BASE = 16;

  localparam int EXC_MRET             = 0;
  localparam int EXC_ECALL            = 1;
  localparam int EXC_EBREAK           = 2;
  localparam int EXC_MISALIGNED_INST  = 3;
  localparam int EXC_ILLEGAL_INST     = 4;
  localparam int EXC_MISALIGNED_STORE = 5;
  localparam int EXC_MISALIGNED_LOAD  = 6;

  typedef struct packed {
    logic        valid;
    logic [4:0]  code;
    logic [31:0] mtval;
  } exc_sel_t;

  // Highest-priority synchronous exception and the mtval it reports
  function automatic exc_sel_t select_exception(input logic [6:0]  exc,
                                                input logic [31:0] addr,
                                                input logic [31:0] inst);
    exc_sel_t sel;
    sel = '{valid: 1'b1, code: CAUSE_MISALIGNED_INST, mtval: addr};
    if (exc[EXC_MISALIGNED_INST]) begin
      sel.code = CAUSE_MISALIGNED_INST;
    end else if (exc[EXC_ILLEGAL_INST]) begin
      sel.code  = CAUSE_ILLEGAL_INST;
      sel.mtval = inst;
    end else if (exc[EXC_EBREAK]) begin
      sel.code = CAUSE_BREAKPOINT;
    end else if (exc[EXC_MISALIGNED_STORE]) begin
      sel.code = CAUSE_MISALIGNED_STORE;
    end else if (exc[EXC_MISALIGNED_LOAD]) begin
      sel.code = CAUSE_MISALIGNED_LOAD;
    end else if (exc[EXC_ECALL]) begin
      sel.code  = CAUSE_ECALL_M;
      sel.mtval = 32'h0;
    end else begin
      sel = '0;
    end
    return sel;
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_prio_enc.sv
// Interrupt priority encoder: MEI, then MSI, then MTI, then local interrupts
// with the lowest index winning.
module irq_prio_enc
  import trap_ctrl_pkg::*;
#(
  parameter int IRQW = 32
) (
  input  logic [IRQW-1:0] pending_i,
  output logic            valid_o,
  output logic [4:0]      code_o
);

  // Bits outside the standard and local interrupt positions carry no source
  logic unused_bits;
  assign unused_bits = ^{pending_i[15:12], pending_i[10:8],
                         pending_i[6:4], pending_i[2:0]};

  // Later assignments override earlier ones, so the scan runs low-to-high priority
  always_comb begin
    valid_o = 1'b0;
    code_o  = 5'd0;
    for (int i = IRQW - 1; i >= CAUSE_LOCAL_BASE; i--) begin
      if (pending_i[i]) begin
        valid_o = 1'b1;
        code_o  = 5'(i);
      end
    end
    if (pending_i[CAUSE_MTI]) begin
      valid_o = 1'b1;
      code_o  = CAUSE_MTI;
    end
    if (pending_i[CAUSE_MSI]) begin
      valid_o = 1'b1;
      code_o  = CAUSE_MSI;
    end
    if (pending_i[CAUSE_MEI]) begin
      valid_o = 1'b1;
      code_o  = CAUSE_MEI;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: stall fan-out, interrupt/exception arbitration,
// trap entry/return sequencing and CSR update strobes.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int          NUM_STAGES = 6,
  parameter int          NUM_LIRQ   = 16,
  parameter logic [31:0] BOOT_ADDR  = BOOT_ADDR_DEFAULT,
  localparam int         IRQW       = 16 + NUM_LIRQ
) (
  input  logic                  clk_i,
  input  logic                  n_rst_i,
  input  logic [NUM_STAGES-1:0] stallreq_i,
  input  logic [6:0]            exception_i,
  input  logic [31:0]           inst_addr_i,
  input  logic [31:0]           inst_i,
  input  logic                  mstatus_ie_i,
  input  logic [IRQW-1:0]       mie_i,
  input  logic [IRQW-1:0]       mip_i,
  input  logic [31:0]           mtvec_i,
  input  logic [31:0]           epc_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic                  flush_o,
  output logic [31:0]           new_pc_o,
  output logic                  set_cause_o,
  output logic [31:0]           mcause_o,
  output logic                  set_epc_o,
  output logic [31:0]           epc_o,
  output logic                  set_mtval_o,
  output logic [31:0]           mtval_o,
  output logic                  mstatus_ie_clear_o,
  output logic                  mstatus_ie_set_o
);

  state_e      state_q, state_d;
  logic        cause_int_q, cause_int_d;
  logic [4:0]  cause_code_q, cause_code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] mtval_q, mtval_d;

  logic [IRQW-1:0] irq_pending;
  logic            irq_valid;
  logic [4:0]      irq_code;
  exc_sel_t        exc_sel;
  logic            trap;
  logic            mret;
  logic            any_stall;
  logic [31:0]     trap_base;
  logic [31:0]     trap_target;

  // A stall in a later stage must also hold every earlier stage
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stall
    assign stall_o[gi] = |stallreq_i[NUM_STAGES-1:gi];
  end

  assign any_stall   = |stallreq_i;
  assign irq_pending = (mie_i & mip_i) & {IRQW{mstatus_ie_i}};

  irq_prio_enc #(
    .IRQW(IRQW)
  ) u_irq_prio_enc (
    .pending_i(irq_pending),
    .valid_o  (irq_valid),
    .code_o   (irq_code)
  );

  assign exc_sel = select_exception(exception_i, inst_addr_i, inst_i);
  assign trap    = irq_valid | exc_sel.valid;
  assign mret    = exception_i[EXC_MRET];

  // Vectored offset only for interrupts in mode 01; modes 10/11 fall back to direct
  assign trap_base   = {mtvec_i[31:2], 2'b00};
  assign trap_target = (mtvec_i[1:0] == 2'b01 && cause_int_q)
                       ? trap_base + {25'd0, cause_code_q, 2'b00}
                       : trap_base;

  assign mcause_o = {cause_int_q, 26'd0, cause_code_q};
  assign epc_o    = epc_q;
  assign mtval_o  = mtval_q;

  always_comb begin
    state_d            = state_q;
    cause_int_d        = cause_int_q;
    cause_code_d       = cause_code_q;
    epc_d              = epc_q;
    mtval_d            = mtval_q;
    flush_o            = 1'b0;
    new_pc_o           = 32'h0;
    set_cause_o        = 1'b0;
    set_epc_o          = 1'b0;
    set_mtval_o        = 1'b0;
    mstatus_ie_clear_o = 1'b0;
    mstatus_ie_set_o   = 1'b0;

    unique case (state_q)
      ST_RESET: begin
        flush_o  = 1'b1;
        new_pc_o = BOOT_ADDR;
        state_d  = ST_OPERATING;
      end

      ST_OPERATING: begin
        // Trap context is latched here and frozen until the redirect
        if (trap) begin
          epc_d = inst_addr_i;
          if (irq_valid) begin
            cause_int_d  = 1'b1;
            cause_code_d = irq_code;
            mtval_d      = 32'h0;
          end else begin
            cause_int_d  = 1'b0;
            cause_code_d = exc_sel.code;
            mtval_d      = exc_sel.mtval;
          end
          state_d = any_stall ? ST_DRAIN : ST_TRAP_TAKEN;
        end else if (mret) begin
          state_d = ST_TRAP_RETURN;
        end
      end

      ST_DRAIN: begin
        if (!any_stall) begin
          state_d = ST_TRAP_TAKEN;
        end
      end

      ST_TRAP_TAKEN: begin
        flush_o            = 1'b1;
        new_pc_o           = trap_target;
        set_cause_o        = 1'b1;
        set_epc_o          = 1'b1;
        set_mtval_o        = 1'b1;
        mstatus_ie_clear_o = 1'b1;
        state_d            = ST_OPERATING;
      end

      ST_TRAP_RETURN: begin
        flush_o          = 1'b1;
        new_pc_o         = epc_i;
        mstatus_ie_set_o = 1'b1;
        state_d          = ST_OPERATING;
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q      <= ST_RESET;
      cause_int_q  <= 1'b0;
      cause_code_q <= 5'd0;
      epc_q        <= 32'h0;
      mtval_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      cause_int_q  <= cause_int_d;
      cause_code_q <= cause_code_d;
      epc_q        <= epc_d;
      mtval_q      <= mtval_d;
    end
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- NUM_STAGES, 6: stall vector width.
- NUM_LIRQ, 16: local interrupts, range 0..16; local interrupt i uses cause 16+i.
- BOOT_ADDR, 32'h0000_0000: redirect PC after reset.
REQ-002 Derived width: IRQW = 16+NUM_LIRQ.
REQ-003 Ports (name, direction, width, meaning):
- clk_i, in, 1: the single clock.
- n_rst_i, in, 1: reset, asynchronous, active-low.
- stallreq_i, in, NUM_STAGES: per-stage stall request; index 0 is the PC stage.
- exception_i, in, 7: {misaligned_load, misaligned_store, illegal_inst, misaligned_inst, ebreak, ecall, mret}.
- inst_addr_i, in, 32: address of the instruction that reports the exception.
- inst_i, in, 32: that instruction's encoding.
- mstatus_ie_i, in, 1: global interrupt enable.
- mie_i, in, IRQW: interrupt enables. Bits 3, 7, 11 are MSI, MTI, MEI; bits 16+ are local.
- mip_i, in, IRQW: interrupt pending, same bit layout as mie_i.
- mtvec_i, in, 32: trap vector.
- epc_i, in, 32: current mepc.
- stall_o, out, NUM_STAGES: stage stall vector.
- flush_o, out, 1: pipeline flush.
- new_pc_o, out, 32: redirect target.
- set_cause_o, out, 1: mcause write strobe.
- mcause_o, out, 32: {interrupt bit, 26'b0, code[4:0]}.
- set_epc_o, out, 1: mepc write strobe.
- epc_o, out, 32: mepc write data.
- set_mtval_o, out, 1: mtval write strobe.
- mtval_o, out, 32: mtval write data.
- mstatus_ie_clear_o, out, 1: clear mstatus.MIE.
- mstatus_ie_set_o, out, 1: set mstatus.MIE.

Function
REQ-004 stall_o[k] SHALL equal the OR of stallreq_i[j] for all j>=k; this is combinational.
REQ-005 Pending interrupt set SHALL be mie_i & mip_i, gated by mstatus_ie_i.
REQ-006 Interrupt priority SHALL be: MEI(11), then MSI(3), then MTI(7), then local interrupts with the lowest index highest (cause 16+i).
REQ-007 Exception priority SHALL be: misaligned_inst(0), illegal(2), ebreak(3), misaligned_store(6), misaligned_load(4), ecall(11).
REQ-008 Any enabled interrupt SHALL win over any exception in the same cycle.
REQ-009 FSM states SHALL be RESET, OPERATING, DRAIN, TRAP_TAKEN, TRAP_RETURN.
REQ-010 RESET SHALL go to OPERATING after one cycle.
REQ-011 OPERATING transitions:
- trap and stallreq_i==0: go to TRAP_TAKEN.
- trap and stallreq_i!=0: go to DRAIN.
- mret without a trap: go to TRAP_RETURN.
- otherwise: stay in OPERATING.
REQ-012 DRAIN SHALL hold until stallreq_i==0, then go to TRAP_TAKEN.
REQ-013 TRAP_TAKEN and TRAP_RETURN SHALL each last exactly one cycle, then return to OPERATING.
REQ-014 When a trap is detected in OPERATING, mcause_o, epc_o (=inst_addr_i) and mtval_o SHALL register on that edge.
REQ-015 These registers SHALL hold unchanged through DRAIN; new interrupts or exceptions arriving during DRAIN are ignored.
REQ-016 mtval value by trap type:
- inst_i for illegal instruction.
- inst_addr_i for misaligned-inst, ebreak, misaligned load and misaligned store.
- 0 for interrupts and ecall.
REQ-017 In TRAP_TAKEN the block SHALL assert, for one cycle only: flush_o, set_cause_o, set_epc_o, set_mtval_o, mstatus_ie_clear_o.
REQ-018 In TRAP_TAKEN new_pc_o = {mtvec_i[31:2],2'b00}, plus 4*code when mtvec_i[1:0]==2'b01 and the trap is an interrupt.
REQ-019 mtvec modes 2'b10 and 2'b11 SHALL behave as direct mode.
REQ-020 In TRAP_RETURN the block SHALL assert flush_o and mstatus_ie_set_o, with new_pc_o=epc_i.
REQ-021 In RESET state the block SHALL assert flush_o=1 with new_pc_o=BOOT_ADDR.
REQ-022 In OPERATING and DRAIN, all strobes and flush_o SHALL be 0 and new_pc_o=0.
REQ-023 Trap and mret in the same cycle: the trap SHALL win and mret is dropped.
REQ-024 Latency: trap detected at edge N with no stall gives redirect during cycle N+1.

Reset
REQ-025 On n_rst_i low the block SHALL immediately set state to RESET, even mid-trap or mid-DRAIN.
REQ-026 Reset values: mcause_o, epc_o, mtval_o = 0; all strobes = 0; stall_o follows REQ-004.
REQ-027 After n_rst_i rises, the first clock cycle SHALL be the RESET redirect of REQ-021.

Structure
REQ-028 The following SHALL live in defines.v: state encodings (one-hot, 5 bits), cause codes, exception_i bit indices, and BOOT_ADDR default.
REQ-029 Interrupt selection SHALL be a sub-module irq_prio_enc, parametrised by IRQW, producing valid and code[4:0].

Verification
REQ-030 Stall fan-out: stallreq_i=6'b001000 -> stall_o=6'b001111, with no state change.
REQ-031 Vectored interrupt:
- Stimulus: mtvec_i=32'h100 with mode 01, mstatus_ie_i=1, mie_i=mip_i=bit 18, inst_addr_i=32'h40.
- Required next cycle: flush_o=1, new_pc_o=32'h148, mcause_o=32'h8000_0012, epc_o=32'h40, mtval_o=0.
REQ-032 Illegal instruction during a stall:
- Stimulus: illegal_inst with inst_i=32'hFFFF_FFFF and stallreq_i[4]=1 for 3 cycles; MEI rises during DRAIN.
- Required: strobes appear 1 cycle after the stall clears, mcause_o=2, mtval_o=32'hFFFF_FFFF.
REQ-033 Interrupt over exception and mret:
- Stimulus: MEI, ecall and mret all asserted in one cycle.
- Required: mcause_o=32'h8000_000B, no mstatus_ie_set_o.
REQ-034 mret:
- Stimulus: mret alone, epc_i=32'h200.
- Required next cycle: flush_o=1, new_pc_o=32'h200, mstatus_ie_set_o=1.
REQ-035 Reset mid-DRAIN:
- Stimulus: assert n_rst_i low while in DRAIN.
- Required: all strobes 0 immediately; after release, one cycle of flush_o=1 with new_pc_o=BOOT_ADDR.
